// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and period of an asynchronous PWM input and
// flags a line held at one level for longer than TIMEOUT cycles.
module pwm_capture #(
    parameter int unsigned   CW      = 8,
    parameter logic [CW-1:0] TIMEOUT = CW'(100)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          pwm_in,
    output logic [CW-1:0] high_time,
    output logic [CW-1:0] period,
    output logic          meas_valid,
    output logic          stuck_hi,
    output logic          stuck_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic sync1_q, sync1_d;
    logic s_q, s_d;
    logic s_prev_q, s_prev_d;

    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CW-1:0] lo_cnt_q, lo_cnt_d;
    logic [CW-1:0] high_time_q, high_time_d;
    logic [CW-1:0] period_q, period_d;
    logic          meas_valid_q, meas_valid_d;
    logic          stuck_hi_q, stuck_hi_d;
    logic          stuck_lo_q, stuck_lo_d;

    logic rise;
    logic fall;
    logic hi_at_limit;
    logic lo_at_limit;

    // Two-stage synchronizer plus one-cycle delay for edge detection
    always_comb begin
        sync1_d  = pwm_in;
        s_d      = sync1_q;
        s_prev_d = s_q;
    end

    assign rise        = s_q & ~s_prev_q;
    assign fall        = ~s_q & s_prev_q;
    assign hi_at_limit = (hi_cnt_q >= TIMEOUT);
    assign lo_at_limit = (lo_cnt_q >= TIMEOUT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an edge always takes precedence over a timeout
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise) state_d = S_HIGH;
                end
                S_HIGH: begin
                    if (fall) state_d = S_LOW;
                    else if (hi_at_limit) state_d = S_IDLE;
                end
                S_LOW: begin
                    if (rise) state_d = S_HIGH;
                    else if (lo_at_limit) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Counters, measurement registers and stuck flags
    always_comb begin
        hi_cnt_d     = hi_cnt_q;
        lo_cnt_d     = lo_cnt_q;
        high_time_d  = high_time_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        stuck_hi_d   = stuck_hi_q;
        stuck_lo_d   = stuck_lo_q;

        if (!en) begin
            hi_cnt_d   = '0;
            lo_cnt_d   = '0;
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
        end else begin
            if (rise || fall) begin
                stuck_hi_d = 1'b0;
                stuck_lo_d = 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    hi_cnt_d = rise ? CW'(1) : '0;
                    lo_cnt_d = '0;
                end
                S_HIGH: begin
                    if (fall) begin
                        lo_cnt_d = CW'(1);
                    end else if (!hi_at_limit) begin
                        hi_cnt_d = hi_cnt_q + CW'(1);
                    end else begin
                        stuck_hi_d = 1'b1;
                        stuck_lo_d = 1'b0;
                        hi_cnt_d   = '0;
                        lo_cnt_d   = '0;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        high_time_d  = hi_cnt_q;
                        period_d     = hi_cnt_q + lo_cnt_q;
                        meas_valid_d = 1'b1;
                        hi_cnt_d     = CW'(1);
                        lo_cnt_d     = '0;
                    end else if (!lo_at_limit) begin
                        lo_cnt_d = lo_cnt_q + CW'(1);
                    end else begin
                        stuck_lo_d = 1'b1;
                        stuck_hi_d = 1'b0;
                        hi_cnt_d   = '0;
                        lo_cnt_d   = '0;
                    end
                end
                default: begin
                    hi_cnt_d = '0;
                    lo_cnt_d = '0;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            s_q          <= 1'b0;
            s_prev_q     <= 1'b0;
            hi_cnt_q     <= '0;
            lo_cnt_q     <= '0;
            high_time_q  <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            stuck_hi_q   <= 1'b0;
            stuck_lo_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            s_q          <= s_d;
            s_prev_q     <= s_prev_d;
            hi_cnt_q     <= hi_cnt_d;
            lo_cnt_q     <= lo_cnt_d;
            high_time_q  <= high_time_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            stuck_hi_q   <= stuck_hi_d;
            stuck_lo_q   <= stuck_lo_d;
        end
    end

    assign high_time  = high_time_q;
    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign stuck_hi   = stuck_hi_q;
    assign stuck_lo   = stuck_lo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture; expected measurements are queued as
// each period is driven and compared whenever the DUT pulses meas_valid.
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       pwm_in;
    logic [7:0] high_time;
    logic [7:0] period;
    logic       meas_valid;
    logic       stuck_hi;
    logic       stuck_lo;

    typedef struct packed {
        logic [7:0] ht;
        logic [7:0] per;
    } meas_t;

    meas_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_pushed = 0;
    int    n_popped = 0;

    pwm_capture dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pwm_in     (pwm_in),
        .high_time  (high_time),
        .period     (period),
        .meas_valid (meas_valid),
        .stuck_hi   (stuck_hi),
        .stuck_lo   (stuck_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_period(input int h, input int l, input bit push);
        pwm_in = 1'b1;
        wait_cyc(h);
        pwm_in = 1'b0;
        wait_cyc(l);
        if (push) begin
            exp_q.push_back('{ht: 8'(h), per: 8'(h + l)});
            n_pushed++;
        end
    endtask

    // Scoreboard: every measurement pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_meas", 32'(meas_valid), 32'd0);
            end else begin
                meas_t e;
                e = exp_q.pop_front();
                n_popped++;
                check("high_time", 32'(high_time), 32'(e.ht));
                check("period", 32'(period), 32'(e.per));
            end
        end
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        pwm_in = 1'b0;
        wait_cyc(3);
        check("rst_high_time", 32'(high_time), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_meas_valid", 32'(meas_valid), 32'd0);
        check("rst_stuck_hi", 32'(stuck_hi), 32'd0);
        check("rst_stuck_lo", 32'(stuck_lo), 32'd0);
        rst = 1'b0;
        wait_cyc(4);

        // Steady 3 high / 7 low
        for (int i = 0; i < 4; i++) drive_period(3, 7, 1'b1);
        // Duty ramp on a 10-cycle period
        for (int d = 1; d <= 9; d++) drive_period(d, 10 - d, 1'b1);
        // Narrow 1/1 pulses
        for (int i = 0; i < 6; i++) drive_period(1, 1, 1'b1);
        // Levels lasting exactly TIMEOUT cycles are measured normally
        drive_period(100, 5, 1'b1);
        drive_period(3, 100, 1'b1);
        drive_period(2, 2, 1'b1);

        // Stuck high: flag on the 101st synchronized high cycle
        pwm_in = 1'b1;
        wait_cyc(102);
        check("stuck_hi_before", 32'(stuck_hi), 32'd0);
        wait_cyc(1);
        check("stuck_hi_set", 32'(stuck_hi), 32'd1);
        check("stuck_hi_lo_clear", 32'(stuck_lo), 32'd0);
        wait_cyc(5);
        check("stuck_hi_hold_ht", 32'(high_time), 32'd2);
        check("stuck_hi_hold_per", 32'(period), 32'd4);
        check("stuck_hi_still", 32'(stuck_hi), 32'd1);
        pwm_in = 1'b0;
        wait_cyc(2);
        check("stuck_hi_pre_fall", 32'(stuck_hi), 32'd1);
        wait_cyc(1);
        check("stuck_hi_cleared", 32'(stuck_hi), 32'd0);
        wait_cyc(2);
        drive_period(4, 6, 1'b1);
        drive_period(5, 5, 1'b1);

        // Stuck low after a short high
        pwm_in = 1'b1;
        wait_cyc(2);
        pwm_in = 1'b0;
        wait_cyc(102);
        check("stuck_lo_before", 32'(stuck_lo), 32'd0);
        wait_cyc(1);
        check("stuck_lo_set", 32'(stuck_lo), 32'd1);
        check("stuck_lo_hi_clear", 32'(stuck_hi), 32'd0);
        check("stuck_lo_hold_ht", 32'(high_time), 32'd5);
        check("stuck_lo_hold_per", 32'(period), 32'd10);
        pwm_in = 1'b1;
        wait_cyc(2);
        check("stuck_lo_pre_rise", 32'(stuck_lo), 32'd1);
        wait_cyc(1);
        check("stuck_lo_cleared", 32'(stuck_lo), 32'd0);
        pwm_in = 1'b0;
        wait_cyc(7);
        exp_q.push_back('{ht: 8'd3, per: 8'd10});
        n_pushed++;

        // Enable dropped in the middle of a high phase
        pwm_in = 1'b1;
        wait_cyc(5);
        en = 1'b0;
        wait_cyc(1);
        check("en_off_meas_valid", 32'(meas_valid), 32'd0);
        check("en_off_hold_ht", 32'(high_time), 32'd3);
        check("en_off_hold_per", 32'(period), 32'd10);
        wait_cyc(2);
        en = 1'b1;
        wait_cyc(4);
        pwm_in = 1'b0;
        wait_cyc(4);
        drive_period(3, 7, 1'b1);

        // Reset asserted in the middle of a high phase
        pwm_in = 1'b1;
        wait_cyc(6);
        rst = 1'b1;
        wait_cyc(1);
        check("midrst_high_time", 32'(high_time), 32'd0);
        check("midrst_period", 32'(period), 32'd0);
        check("midrst_meas_valid", 32'(meas_valid), 32'd0);
        pwm_in = 1'b0;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(3);
        drive_period(4, 6, 1'b1);
        drive_period(6, 4, 1'b1);
        pwm_in = 1'b1;
        wait_cyc(8);
        pwm_in = 1'b0;
        wait_cyc(8);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("meas_count", 32'(n_popped), 32'(n_pushed));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM receiver for the LED animation path: it samples an asynchronous PWM waveform, such as the output of the duty-cycle-ramping controller/PWM pair, and measures each full period. It reports the high time and the period in clock cycles and flags a line stuck high or stuck low. Benches use it to close the loop on the breathing-LED generator, checking the ramp 0..K..0 duty sequence. It also serves as a general duty-cycle input for later animation blocks.

## Interface
- `CW`, 8: width of the high-time, low-time and period counters.
- `TIMEOUT`, 8'd100: maximum cycles one level may persist before a stuck flag is raised. Legal range is 1 ≤ TIMEOUT ≤ (2^CW−1)/2.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset; synchronous and active-high.
- `en`  in  1: capture enable; low forces IDLE.
- `pwm_in`  in  1: asynchronous PWM input.
- `high_time`  out  CW: cycles high in the last complete period.
- `period`  out  CW: cycles in the last complete period (high + low).
- `meas_valid`  out  1: one-cycle pulse; `high_time`/`period` updated this cycle.
- `stuck_hi`  out  1: level flag; input held high longer than TIMEOUT.
- `stuck_lo`  out  1: level flag; input held low longer than TIMEOUT.

## Operation
- **Input conditioning:** 2-FF synchronizer on `pwm_in` gives `s`; `s_d` is `s` delayed one cycle.
  - rise = s & ~s_d
  - fall = ~s & s_d
- **FSM states:** IDLE, HIGH, LOW.
- **IDLE:**
  - Counters are cleared.
  - The first partial period is discarded.
  - On rise: hi_cnt←1, go to HIGH.
- **HIGH**, each cycle with s=1 and no fall:
  - If hi_cnt < TIMEOUT: hi_cnt+1.
  - Else (hi_cnt == TIMEOUT): stuck_hi←1, go to IDLE.
- **HIGH, on fall:** lo_cnt←1, go to LOW.
- **LOW**, each cycle with s=0 and no rise:
  - If lo_cnt < TIMEOUT: lo_cnt+1.
  - Else: stuck_lo←1, go to IDLE.
- **LOW, on rise:**
  - Register high_time←hi_cnt and period←hi_cnt+lo_cnt.
  - meas_valid←1.
  - hi_cnt←1, go to HIGH.
- **Counter width:** the constraint on TIMEOUT guarantees hi_cnt+lo_cnt fits CW bits. No saturation logic is needed.
- **Stuck flags:**
  - Both clear on any rise or fall of `s`, whatever the state.
  - At most one flag is set at a time.
  - `high_time`/`period` hold their last valid values while stuck.
- **en=0:**
  - The FSM goes to IDLE next cycle.
  - Counters and stuck flags clear.
  - meas_valid=0.
  - `high_time`/`period` hold.
  - The synchronizer keeps running.
- **Boundary cases:**
  - Edge and timeout in the same cycle: the edge wins.
  - A level lasting exactly TIMEOUT cycles is measured normally.
  - A level lasting TIMEOUT+1 cycles raises the flag.
  - Single-cycle high or low pulses (≥1 cycle after sync) are measured: high_time=1 or period−high_time=1.

## Timing
- **Reset values:**
  - high_time=0, period=0
  - meas_valid=0, stuck_hi=0, stuck_lo=0
  - FSM=IDLE
  - synchronizer and s_d = 0
- **Measurement latency:** `pwm_in` rising after clk edge k gives meas_valid high during the cycle after edge k+3.
  - edge k+1: sync stage 1
  - edge k+2: `s`
  - edge k+3: registered outputs
- **Stuck latency:** the stuck flag asserts TIMEOUT+1 cycles after the last synchronized edge.
- **Back-to-back periods:** meas_valid pulses once per period. There is no gap and no lost period.
- **Outputs:** all registered; no combinational path from inputs.
- **Mid-operation reset:** reset during any state returns everything to reset values on that edge. The next measurement needs two full rising edges.

## Test plan
1. **Steady PWM:** `pwm_in` 3 high / 7 low, repeated. The first period is discarded; then meas_valid once every 10 cycles with high_time=3, period=10.
2. **Ramp check:** drive from the T=10 PWM generator with duty stepping 1..9. Each step yields high_time=duty, period=10 after at most one discarded period.
3. **Stuck high:**
   - duty 10 (held high) with TIMEOUT=100: stuck_hi=1 on the 101st high cycle, no meas_valid, outputs hold.
   - Then the input toggles: stuck_hi clears on the first edge.
   - Valid data resumes after one full period.
4. **Stuck low:** duty 0: stuck_lo=1 after 101 low cycles. A low of exactly 100 cycles followed by a rise gives a normal measurement (period = high+100), flag 0.
5. **Enable/reset mid-period:** en=0 or rst=1 in the middle of HIGH. Counters clear, no meas_valid; the first meas_valid comes after the second subsequent rising edge, with correct values.
6. **Narrow pulses:** 1 high / 1 low input. Every 2 cycles meas_valid with high_time=1, period=2.
